trace_commit_arbiter: RTL



---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 41 ++++
 rtl/trace_commit_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared record type, widths and reset constants for trace_commit_arbiter
// TRACE_TIMESTAMP_EN adds a 64-bit enqueue cycle stamp to every record.
package trace_pkg;

    localparam int TRACE_XLEN_MAX = 64;
    localparam int TRACE_ILEN_MAX = 32;
    localparam int CYCLE_W        = 64;

    typedef struct packed {
        logic [TRACE_XLEN_MAX-1:0] pc;
        logic [TRACE_ILEN_MAX-1:0] inst;
        logic [TRACE_XLEN_MAX-1:0] wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [CYCLE_W-1:0]        cycle;
`endif
    } trace_rec_t;

    localparam trace_rec_t REC_RESET = '0;

    function automatic int hartid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - per-hart synchronous FIFO with extra-MSB wrapping pointers
// Caller never pushes when full unless it pops in the same cycle.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/trace_commit_arbiter.sv
// rtl/trace_commit_arbiter.sv - round-robin merge of per-hart commit trace into one checker port
// TRACE_TIMESTAMP_EN adds out_cycle carrying each record's enqueue cycle.
module trace_commit_arbiter
    import trace_pkg::*;
#(
    parameter int NHARTS = 2,
    parameter int DEPTH  = 8,
    parameter int XLEN   = 64,
    parameter int ILEN   = 32,
    localparam int HW    = hartid_w(NHARTS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NHARTS-1:0]      in_valid,
    input  logic [NHARTS*XLEN-1:0] in_pc,
    input  logic [NHARTS*ILEN-1:0] in_inst,
    input  logic [NHARTS*XLEN-1:0] in_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [HW-1:0]          out_hartid,
    output logic [XLEN-1:0]        out_pc,
    output logic [ILEN-1:0]        out_inst,
    output logic [XLEN-1:0]        out_wdata,
    output logic                   overflow,
    output logic [HW-1:0]          overflow_hart,
`ifdef TRACE_TIMESTAMP_EN
    output logic [63:0]            out_cycle,
`endif
    output logic                   drained
);

    trace_rec_t [NHARTS-1:0] in_rec;
    trace_rec_t [NHARTS-1:0] head;
    logic [NHARTS-1:0]       full, empty, push, pop, drop;

    logic          load, found;
    logic [HW-1:0] grant;
    int            scan_idx;

    logic          out_valid_q, out_valid_d;
    trace_rec_t    out_rec_q, out_rec_d;
    logic [HW-1:0] out_hartid_q, out_hartid_d;
    logic [HW-1:0] rr_q, rr_d;
    logic          ovf_q, ovf_d;
    logic [HW-1:0] ovf_hart_q, ovf_hart_d;

`ifdef TRACE_TIMESTAMP_EN
    logic [CYCLE_W-1:0] cycle_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 1'b1;
    end
`endif

    // A full FIFO still takes a push when the arbiter drains it the same cycle.
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            in_rec[h]       = REC_RESET;
            in_rec[h].pc    = TRACE_XLEN_MAX'(in_pc[h*XLEN +: XLEN]);
            in_rec[h].inst  = TRACE_ILEN_MAX'(in_inst[h*ILEN +: ILEN]);
            in_rec[h].wdata = TRACE_XLEN_MAX'(in_wdata[h*XLEN +: XLEN]);
`ifdef TRACE_TIMESTAMP_EN
            in_rec[h].cycle = cycle_q;
`endif
            push[h] = in_valid[h] & (~full[h] | pop[h]);
            drop[h] = in_valid[h] & full[h] & ~pop[h];
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_fifo
        trace_fifo #(
            .W     ($bits(trace_rec_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[h]),
            .wdata (in_rec[h]),
            .pop   (pop[h]),
            .full  (full[h]),
            .empty (empty[h]),
            .head  (head[h])
        );
    end

    assign load = ~out_valid_q | out_ready;

    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_idx = 0;
        for (int i = 0; i < NHARTS; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NHARTS) scan_idx = scan_idx - NHARTS;
            if (!found && !empty[scan_idx]) begin
                found = 1'b1;
                grant = HW'(scan_idx);
            end
        end
    end

    always_comb begin
        pop          = '0;
        out_valid_d  = out_valid_q;
        out_rec_d    = out_rec_q;
        out_hartid_d = out_hartid_q;
        rr_d         = rr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                pop[grant]   = 1'b1;
                out_rec_d    = head[grant];
                out_hartid_d = grant;
                rr_d         = (grant == HW'(NHARTS - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // Descending scan so the lowest dropping hart wins the first-drop latch.
    always_comb begin
        ovf_d      = ovf_q | (|drop);
        ovf_hart_d = ovf_hart_q;
        if (!ovf_q) begin
            for (int h = NHARTS - 1; h >= 0; h--) begin
                if (drop[h]) ovf_hart_d = HW'(h);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_rec_q    <= REC_RESET;
            out_hartid_q <= '0;
            rr_q         <= '0;
            ovf_q        <= 1'b0;
            ovf_hart_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_rec_q    <= out_rec_d;
            out_hartid_q <= out_hartid_d;
            rr_q         <= rr_d;
            ovf_q        <= ovf_d;
            ovf_hart_q   <= ovf_hart_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_hartid    = out_hartid_q;
    assign out_pc        = out_rec_q.pc[XLEN-1:0];
    assign out_inst      = out_rec_q.inst[ILEN-1:0];
    assign out_wdata     = out_rec_q.wdata[XLEN-1:0];
    assign overflow      = ovf_q;
    assign overflow_hart = ovf_hart_q;
`ifdef TRACE_TIMESTAMP_EN
    assign out_cycle     = out_rec_q.cycle;
`endif
    assign drained       = (&empty) & ~out_valid_q;

endmodule
